// File: rtl/grad_mag_dir.sv
// rtl/grad_mag_dir.sv - per-lane gradient magnitude, direction sector and per-frame peak magnitude
module grad_mag_dir #(
  parameter int         LANES  = 5,
  parameter logic [9:0] TAN_LO = 10'd106,
  parameter logic [9:0] TAN_HI = 10'd618
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              in_valid,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic signed [7:0] gx [LANES],
  input  logic signed [7:0] gy [LANES],
  output logic              out_valid,
  output logic        [7:0] mag [LANES],
  output logic        [1:0] dir [LANES],
  output logic        [7:0] frame_max,
  output logic              frame_max_valid
);

  function automatic logic [7:0] abs8(input logic [7:0] v);
    // |-128| wraps to 8'h80, which is exactly 128 unsigned
    return v[7] ? (~v + 8'd1) : v;
  endfunction

  logic       v1, fs1, fe1;
  logic [7:0] ax1 [LANES];
  logic [7:0] ay1 [LANES];
  logic       sx1 [LANES];
  logic       sy1 [LANES];

  logic        v2, fs2, fe2;
  logic [8:0]  sum2 [LANES];
  logic [17:0] pa2  [LANES];
  logic [17:0] pb2  [LANES];
  logic [17:0] py2  [LANES];
  logic        sx2  [LANES];
  logic        sy2  [LANES];

  logic [7:0] mag_c [LANES];
  logic [1:0] dir_c [LANES];
  logic [7:0] beat_max;
  logic [7:0] run_max;
  logic [7:0] upd_max;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      v1  <= 1'b0;
      fs1 <= 1'b0;
      fe1 <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        ax1[l] <= '0;
        ay1[l] <= '0;
        sx1[l] <= 1'b0;
        sy1[l] <= 1'b0;
      end
    end else begin
      v1  <= in_valid;
      fs1 <= in_valid & frame_start;
      fe1 <= in_valid & frame_end;
      for (int l = 0; l < LANES; l++) begin
        ax1[l] <= abs8(gx[l]);
        ay1[l] <= abs8(gy[l]);
        sx1[l] <= gx[l][7];
        sy1[l] <= gy[l][7];
      end
    end
  end

  // Sector test compares ay*256 against ax*tan(angle)*256 to avoid a divider
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      v2  <= 1'b0;
      fs2 <= 1'b0;
      fe2 <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        sum2[l] <= '0;
        pa2[l]  <= '0;
        pb2[l]  <= '0;
        py2[l]  <= '0;
        sx2[l]  <= 1'b0;
        sy2[l]  <= 1'b0;
      end
    end else begin
      v2  <= v1;
      fs2 <= fs1;
      fe2 <= fe1;
      for (int l = 0; l < LANES; l++) begin
        sum2[l] <= {1'b0, ax1[l]} + {1'b0, ay1[l]};
        pa2[l]  <= 18'(ax1[l]) * 18'(TAN_LO);
        pb2[l]  <= 18'(ax1[l]) * 18'(TAN_HI);
        py2[l]  <= {2'b00, ay1[l], 8'h00};
        sx2[l]  <= sx1[l];
        sy2[l]  <= sy1[l];
      end
    end
  end

  always_comb begin
    beat_max = '0;
    for (int l = 0; l < LANES; l++) begin
      mag_c[l] = sum2[l][8] ? 8'hFF : sum2[l][7:0];
      if (py2[l] <= pa2[l]) begin
        dir_c[l] = 2'd0;
      end else if (py2[l] > pb2[l]) begin
        dir_c[l] = 2'd2;
      end else if (sx2[l] == sy2[l]) begin
        dir_c[l] = 2'd1;
      end else begin
        dir_c[l] = 2'd3;
      end
      if (mag_c[l] > beat_max) begin
        beat_max = mag_c[l];
      end
    end
    if (fs2) begin
      upd_max = beat_max;
    end else begin
      upd_max = (beat_max > run_max) ? beat_max : run_max;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_valid       <= 1'b0;
      run_max         <= '0;
      frame_max       <= '0;
      frame_max_valid <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        mag[l] <= '0;
        dir[l] <= '0;
      end
    end else begin
      out_valid       <= v2;
      frame_max_valid <= v2 & fe2;
      if (v2) begin
        run_max <= upd_max;
        for (int l = 0; l < LANES; l++) begin
          mag[l] <= mag_c[l];
          dir[l] <= dir_c[l];
        end
        if (fe2) begin
          frame_max <= upd_max;
        end
      end
    end
  end

endmodule

// File: tb/tb_grad_mag_dir.sv
// tb/tb_grad_mag_dir.sv - directed-vector bench for grad_mag_dir
module tb_grad_mag_dir;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              in_valid, frame_start, frame_end;
  logic signed [7:0] gx [5];
  logic signed [7:0] gy [5];
  logic              out_valid;
  logic        [7:0] mag [5];
  logic        [1:0] dir [5];
  logic        [7:0] frame_max;
  logic              frame_max_valid;

  always #5 clk = ~clk;

  grad_mag_dir dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .frame_start(frame_start),
    .frame_end(frame_end), .gx(gx), .gy(gy), .out_valid(out_valid), .mag(mag),
    .dir(dir), .frame_max(frame_max), .frame_max_valid(frame_max_valid)
  );

  typedef struct packed {
    logic [39:0] m;
    logic [9:0]  d;
    logic        fmv;
    logic [7:0]  fm;
  } rec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  rec_t        q [$];
  logic [2:0]  hist;
  logic        cur_v;
  logic [39:0] last_m;
  logic [9:0]  last_d;
  logic [7:0]  exp_fmax;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] p5(input int a0, a1, a2, a3, a4);
    return {a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endfunction

  function automatic logic [9:0] d5(input int a0, a1, a2, a3, a4);
    return {a4[1:0], a3[1:0], a2[1:0], a1[1:0], a0[1:0]};
  endfunction

  function automatic logic [39:0] mag_p();
    logic [39:0] r;
    for (int l = 0; l < 5; l++) r[8*l +: 8] = mag[l];
    return r;
  endfunction

  function automatic logic [9:0] dir_p();
    logic [9:0] r;
    for (int l = 0; l < 5; l++) r[2*l +: 2] = dir[l];
    return r;
  endfunction

  // Reference: integer form of the tan(22.5)/tan(67.5) sector boundaries
  task automatic model(input int x, input int y, output logic [7:0] m, output logic [1:0] d);
    int ax, ay, s;
    ax = (x < 0) ? -x : x;
    ay = (y < 0) ? -y : y;
    s  = ax + ay;
    m  = (s > 255) ? 8'd255 : s[7:0];
    if (ay * 256 <= ax * 106)        d = 2'd0;
    else if (ay * 256 > ax * 618)    d = 2'd2;
    else if ((x < 0) == (y < 0))     d = 2'd1;
    else                             d = 2'd3;
  endtask

  task automatic step();
    rec_t r;
    @(posedge clk);
    #1;
    hist = {hist[1:0], cur_v};
    check("out_valid", 64'(out_valid), 64'(hist[2]));
    if (hist[2]) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard: got output beat, expected none queued");
      end else begin
        r = q.pop_front();
        check("mag", 64'(mag_p()), 64'(r.m));
        check("dir", 64'(dir_p()), 64'(r.d));
        check("frame_max_valid", 64'(frame_max_valid), 64'(r.fmv));
        if (r.fmv) exp_fmax = r.fm;
        last_m = r.m;
        last_d = r.d;
      end
    end else begin
      check("frame_max_valid_idle", 64'(frame_max_valid), 64'd0);
      check("mag_hold", 64'(mag_p()), 64'(last_m));
      check("dir_hold", 64'(dir_p()), 64'(last_d));
    end
    check("frame_max", 64'(frame_max), 64'(exp_fmax));
  endtask

  task automatic beat(input logic v, input logic fs, input logic fe,
                      input logic [39:0] x, input logic [39:0] y,
                      input logic [39:0] em, input logic [9:0] ed,
                      input logic efmv, input logic [7:0] efm);
    rec_t r;
    in_valid    = v;
    frame_start = fs;
    frame_end   = fe;
    for (int l = 0; l < 5; l++) begin
      gx[l] = x[8*l +: 8];
      gy[l] = y[8*l +: 8];
    end
    cur_v = v;
    if (v) begin
      r.m = em; r.d = ed; r.fmv = efmv; r.fm = efm;
      q.push_back(r);
    end
    step();
  endtask

  task automatic idle();
    beat(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 8'd0);
  endtask

  task automatic reset_zero(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_frame_max_valid"}, 64'(frame_max_valid), 64'd0);
    check({tag, "_frame_max"}, 64'(frame_max), 64'd0);
    check({tag, "_mag"}, 64'(mag_p()), 64'd0);
    check({tag, "_dir"}, 64'(dir_p()), 64'd0);
  endtask

  task automatic clear_model();
    q.delete();
    hist     = '0;
    cur_v    = 1'b0;
    last_m   = '0;
    last_d   = '0;
    exp_fmax = '0;
  endtask

  initial begin
    logic [39:0] xs, ys, em;
    logic [9:0]  ed;
    logic [7:0]  m;
    logic [1:0]  d;
    int          xv, yv;

    in_valid = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
    for (int l = 0; l < 5; l++) begin gx[l] = '0; gy[l] = '0; end
    clear_model();
    n_rst = 1'b1;
    #2 n_rst = 1'b0;
    #1 reset_zero("reset_init");
    @(posedge clk);
    #1 n_rst = 1'b1;

    // T2 sectors
    beat(1, 0, 0, p5(3, 0, 4, 4, 0), p5(0, 5, 4, -4, 0),
         p5(3, 5, 8, 8, 0), d5(0, 2, 1, 3, 0), 0, 0);
    // T3 saturation and shallow angle
    beat(1, 0, 0, p5(-128, -128, -128, -128, -128), p5(-128, -128, -128, -128, -128),
         p5(255, 255, 255, 255, 255), d5(1, 1, 1, 1, 1), 0, 0);
    beat(1, 0, 0, p5(100, 100, 100, 100, 100), p5(-20, -20, -20, -20, -20),
         p5(120, 120, 120, 120, 120), d5(0, 0, 0, 0, 0), 0, 0);
    repeat (4) idle();

    // T1 reset mid-stream with beats in flight
    beat(1, 1, 0, p5(9, 9, 9, 9, 9), p5(1, 1, 1, 1, 1), '0, '0, 0, 0);
    beat(1, 0, 1, p5(7, 7, 7, 7, 7), p5(2, 2, 2, 2, 2), '0, '0, 0, 0);
    #2 n_rst = 1'b0;
    #1 reset_zero("reset_mid");
    in_valid = 1'b0;
    clear_model();
    @(posedge clk);
    #1 n_rst = 1'b1;
    idle();
    idle();
    beat(1, 0, 0, p5(3, 0, 4, 4, 0), p5(0, 5, 4, -4, 0),
         p5(3, 5, 8, 8, 0), d5(0, 2, 1, 3, 0), 0, 0);
    repeat (3) idle();

    // T4 three-beat frame with an ignored bubble; T5 single-beat frame
    beat(1, 1, 0, p5(10, 0, 0, 0, 0), p5(0, 0, 0, 0, 0),
         p5(10, 0, 0, 0, 0), d5(0, 0, 0, 0, 0), 0, 0);
    beat(1, 0, 0, p5(0, 0, 100, 0, 0), p5(0, 0, 100, 0, 0),
         p5(0, 0, 200, 0, 0), d5(0, 0, 1, 0, 0), 0, 0);
    beat(0, 1, 1, p5(90, 90, 90, 90, 90), p5(90, 90, 90, 90, 90), '0, '0, 0, 0);
    beat(1, 0, 1, p5(0, 0, 0, 0, 50), p5(0, 0, 0, 0, 0),
         p5(0, 0, 0, 0, 50), d5(0, 0, 0, 0, 0), 1, 200);
    beat(1, 1, 1, p5(0, 0, 0, -40, 0), p5(-20, 0, 0, 37, 0),
         p5(20, 0, 0, 77, 0), d5(2, 0, 0, 3, 0), 1, 77);

    // T6 back-to-back ramp against the reference model
    for (int i = 0; i < 20; i++) begin
      for (int l = 0; l < 5; l++) begin
        xv = i * 9 + l * 7 - 90;
        yv = 40 - i * 6 + l * 9;
        xs[8*l +: 8] = xv[7:0];
        ys[8*l +: 8] = yv[7:0];
        model(xv, yv, m, d);
        em[8*l +: 8] = m;
        ed[2*l +: 2] = d;
      end
      beat(1, 0, 0, xs, ys, em, ed, 0, 0);
    end
    repeat (4) idle();

    check("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
